uart_rx_param: RTL

- Parametrised UART receiver; successor to the fixed 8N1 receive state machine.
- Configurable data width, parity mode and stop-bit count.
- Adds an input synchroniser, start-bit glitch rejection, and parity, framing and break detection.
- Sits between the board RX pin and the command/data path. Delivers one-cycle-valid words to downstream logic.

---
 rtl/uart_rx_param.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, mid-bit sampling,
// start-bit glitch rejection, optional even/odd parity, 1 or 2 stop bits,
// and parity / framing / break flags delivered with a one-cycle valid pulse.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,   // 0 none, 1 even, 2 odd
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);
    localparam int               IDX_W     = $clog2(DATA_BITS);
    localparam logic [15:0]      HALF_CNT  = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0]      FULL_CNT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY_MODE == 2);
    localparam bit               HAS_PAR   = (PARITY_MODE != 0);

    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_rx_param: CLKS_PER_BIT must be 4..65535");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t               state;
    logic                 rx_meta, rx_s;
    logic [15:0]          cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 frame_lat;

    // Two-flop synchroniser; presets to idle-high so reset never looks like a start bit
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with registered word, flags and valid pulse
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            frame_lat    <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Data    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            o_Rx_DV <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt       <= '0;
                    bit_idx   <= '0;
                    stop_idx  <= 1'b0;
                    par_bit   <= 1'b0;
                    frame_lat <= 1'b0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // a start bit that has gone high by mid-bit was only a glitch
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_CNT) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            state   <= HAS_PAR ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (cnt == FULL_CNT) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_CNT) begin
                        cnt <= '0;
                        if (!rx_s) frame_lat <= 1'b1;
                        if (stop_idx == LAST_STOP) state <= DONE;
                        else stop_idx <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    // entered mid-way through the last stop bit, so re-arming here
                    // leaves half a bit of slack for a back-to-back start edge
                    cnt          <= '0;
                    state        <= IDLE;
                    o_Rx_DV      <= 1'b1;
                    o_Rx_Data    <= shreg;
                    o_Parity_Err <= HAS_PAR && ((^shreg ^ par_bit) != ODD);
                    o_Frame_Err  <= frame_lat;
                    o_Break      <= (shreg == '0) && (!HAS_PAR || !par_bit) && frame_lat;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_Busy = (state != IDLE);

endmodule
